imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024, meaning the byte capacity of the attached instruction memory (power of two).
REQ-002 SHALL have parameter AW, default 10, meaning the memory word-port address width, log2(DEPTH_BYTES).
REQ-003 SHALL have one clock and an asynchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-004 SHALL have the fetch port: fetch_req in 1 request; fetch_addr in 32 byte address; fetch_gnt out 1 accepted; fetch_rvalid out 1 data valid; fetch_rdata out 32 instruction; fetch_err out 1 access fault.
REQ-005 SHALL have the loader port: load_req in 1 request; load_addr in 32 byte address; load_wdata in 32 write data; load_be in 4 byte enables; load_gnt out 1 accepted; load_err out 1 dropped write.
REQ-006 SHALL have the memory port: mem_en out 1; mem_we out 1; mem_addr out AW; mem_wdata out 32; mem_be out 4; mem_rdata in 32, valid one cycle after a read.
REQ-007 SHALL have busy  out  1, high while a read is in flight.

Function
REQ-008 SHALL grant at most one requester per cycle; gnt is combinational from req and arbiter state, and a transfer occurs when req and gnt are both high.
REQ-009 SHALL arbitrate round-robin: on simultaneous requests, grant the port not granted last; after reset, the loader has priority.
REQ-010 SHALL drive mem_en=1 in the grant cycle for in-range accesses only, with mem_addr=addr[AW-1:0], mem_we=1 for loader, mem_we=0 and mem_be=4'hF for fetch.
REQ-011 SHALL assert fetch_rvalid exactly one cycle after a fetch grant, with fetch_rdata=mem_rdata (little-endian word: byte addr+0 in bits 7:0).
REQ-012 SHALL treat a fetch with addr[1:0]!=0 or addr>=DEPTH_BYTES as a fault: grant it, issue no memory access, and one cycle later assert fetch_rvalid, fetch_err=1, and fetch_rdata=32'h0000_0013 (NOP).
REQ-013 SHALL grant an out-of-range or misaligned loader write, issue no memory access, and pulse load_err for one cycle after the grant.
REQ-014 SHALL use FSM states IDLE and RESP: IDLE->RESP on a fetch grant; RESP->RESP on a back-to-back fetch grant; RESP->IDLE otherwise; loader grants do not change state.
REQ-015 SHALL allow a new grant (either port) in the same cycle that fetch_rvalid is high, sustaining one fetch per cycle.
REQ-016 SHALL preserve program order: a fetch granted the cycle after a write to the same word returns the new data.
REQ-017 SHALL hold fetch_rdata stable when fetch_rvalid is low.

Reset
REQ-018 SHALL on reset assertion immediately set fetch_gnt, load_gnt, fetch_rvalid, fetch_err, load_err, mem_en, mem_we, and busy to 0, set fetch_rdata to 0, set the FSM to IDLE, and set the last-grant pointer to fetch.
REQ-019 SHALL discard a read in flight at reset; no fetch_rvalid follows reset deassertion.

Configuration
REQ-020 SHALL, when IMEM_ARB_LOAD_LOCK_EN is defined, add input load_lock (1 bit); while it is high, fetch_gnt=0 and the loader is granted whenever it requests, and an in-flight read still completes.
REQ-021 SHALL, when IMEM_ARB_LOAD_LOCK_EN is undefined, have no load_lock port and use pure round-robin.

Structure
REQ-022 SHALL place DEPTH_BYTES default, the NOP constant 32'h0000_0013, the FSM state enum, and the last-grant enum in shared package imem_pkg.
REQ-023 SHALL implement arbitration in sub-module rr_arb2, a two-requester round-robin arbiter with a registered last-grant pointer.

Verification
REQ-024 Fetch only, addr 0x0 then 0x4 in consecutive cycles, memory word0=0x00102083 -> gnt both cycles; rvalid cycles 2 and 3; rdata word0 then word1; err=0.
REQ-025 Simultaneous requests for 4 cycles -> grants alternate loader, fetch, loader, fetch.
REQ-026 Fetch at 0x2, then at 0x400 -> rvalid with err=1, rdata=0x00000013 each; mem_en stays 0.
REQ-027 Loader writes 0xDEADBEEF with be=4'hF to 0x8; fetch 0x8 next cycle -> rdata=0xDEADBEEF.
REQ-028 Reset asserted the cycle after a fetch grant -> no rvalid; busy=0; first grant after release goes to loader on contention.
REQ-029 With IMEM_ARB_LOAD_LOCK_EN defined and load_lock=1, both requesting for 3 cycles -> load_gnt=1 and fetch_gnt=0 in all 3 cycles.

Source files
------------

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory arbiter:
//   DEPTH_BYTES_DEF : default byte capacity of the attached instruction memory
//   NOP_INSN        : instruction returned on a faulted fetch (addi x0,x0,0)
//   arb_state_e     : response FSM states (IDLE / RESP)
//   last_gnt_e      : round-robin last-grant pointer values
//   addr_ok()       : word-aligned and inside the memory
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int unsigned DEPTH_BYTES_DEF = 1024;
  localparam logic [31:0] NOP_INSN        = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

  typedef enum logic {
    LAST_FETCH = 1'b0,
    LAST_LOAD  = 1'b1
  } last_gnt_e;

  // An access is serviceable only when it is word aligned and below the top
  // of the memory; everything else is answered without touching the array.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] depth_bytes);
    return (addr[1:0] == 2'b00) && (addr < depth_bytes);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_arbiter_if
// Bundles the fetch port, the loader port and the memory port of the
// instruction-memory arbiter.
//   master : requester/memory side (drives requests, addresses, mem_rdata)
//   slave  : arbiter side (drives grants, responses and the memory controls)
// Parameter AW is the memory address width.
// -----------------------------------------------------------------------------
interface imem_arbiter_if #(
  parameter int AW = 10
);

  // fetch port
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          fetch_err;

  // loader port
  logic          load_req;
  logic [31:0]   load_addr;
  logic [31:0]   load_wdata;
  logic [3:0]    load_be;
  logic          load_gnt;
  logic          load_err;

  // memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  modport master (
    output fetch_req, fetch_addr,
    output load_req, load_addr, load_wdata, load_be,
    output mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
    input  load_gnt, load_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  fetch_req, fetch_addr,
    input  load_req, load_addr, load_wdata, load_be,
    input  mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
    output load_gnt, load_err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a registered last-grant pointer.
// Grants are combinational from the requests and the pointer.
//   clk, reset   : clock, asynchronous active-high reset
//   i_req_load   : loader request
//   i_req_fetch  : fetch request
//   i_lock       : when high the fetch side is never granted
//   o_gnt_load   : loader grant
//   o_gnt_fetch  : fetch grant
// -----------------------------------------------------------------------------
module rr_arb2
  import imem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req_load,
  input  logic i_req_fetch,
  input  logic i_lock,
  output logic o_gnt_load,
  output logic o_gnt_fetch
);

  last_gnt_e r_last;

  // Reset gates the grants so nothing is accepted while reset is held.
  always_comb begin
    o_gnt_load  = 1'b0;
    o_gnt_fetch = 1'b0;
    if (!reset) begin
      if (i_lock) begin
        o_gnt_load = i_req_load;
      end else if (i_req_load && i_req_fetch) begin
        // Contention: the side that did not win last time goes now.
        if (r_last == LAST_FETCH) o_gnt_load  = 1'b1;
        else                      o_gnt_fetch = 1'b1;
      end else begin
        o_gnt_load  = i_req_load;
        o_gnt_fetch = i_req_fetch;
      end
    end
  end

  // Pointer starts at "fetch" so the loader wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_last <= LAST_FETCH;
    else if (o_gnt_load)  r_last <= LAST_LOAD;
    else if (o_gnt_fetch) r_last <= LAST_FETCH;
  end

endmodule

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Shares one single-port instruction memory between an instruction fetch port
// and a loader (write) port. Round-robin between the two; fetch data returns
// one cycle after the grant. Faulting fetches (misaligned / out of range)
// return a NOP with fetch_err, faulting loader writes are dropped and flagged
// on load_err one cycle after the grant.
//   clk, reset : clock, asynchronous active-high reset
//   load_lock  : (IMEM_ARB_LOAD_LOCK_EN only) block fetch grants, loader wins
//   bus        : imem_arbiter_if.slave (fetch, loader and memory ports)
//   busy       : a fetch response is pending this cycle
// Optional feature macro: IMEM_ARB_LOAD_LOCK_EN (adds the load_lock input).
// -----------------------------------------------------------------------------
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF,
  parameter int          AW          = 10
) (
  input  logic          clk,
  input  logic          reset,
`ifdef IMEM_ARB_LOAD_LOCK_EN
  input  logic          load_lock,
`endif
  imem_arbiter_if.slave bus,
  output logic          busy
);

  logic        w_lock;
  logic        w_fgnt;
  logic        w_lgnt;
  logic        w_fetch_ok;
  logic        w_load_ok;
  logic [31:0] w_rdata;

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  logic        r_err;
  logic        r_load_err;
  logic [31:0] r_rdata_hold;

`ifdef IMEM_ARB_LOAD_LOCK_EN
  assign w_lock = load_lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_fetch_ok = addr_ok(bus.fetch_addr, 32'(DEPTH_BYTES));
  assign w_load_ok  = addr_ok(bus.load_addr,  32'(DEPTH_BYTES));

  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_req_load  (bus.load_req),
    .i_req_fetch (bus.fetch_req),
    .i_lock      (w_lock),
    .o_gnt_load  (w_lgnt),
    .o_gnt_fetch (w_fgnt)
  );

  assign bus.fetch_gnt = w_fgnt;
  assign bus.load_gnt  = w_lgnt;

  // Memory is driven in the grant cycle; faulting accesses never enable it.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.fetch_addr[AW-1:0];
    bus.mem_wdata = bus.load_wdata;
    bus.mem_be    = 4'hF;
    if (w_fgnt && w_fetch_ok) begin
      bus.mem_en = 1'b1;
    end else if (w_lgnt && w_load_ok) begin
      bus.mem_en   = 1'b1;
      bus.mem_we   = 1'b1;
      bus.mem_addr = bus.load_addr[AW-1:0];
      bus.mem_be   = bus.load_be;
    end
  end

  // Response FSM: RESP is the cycle in which fetch data is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    if (w_fgnt) w_state_nxt = RESP;
      RESP:    if (w_fgnt) w_state_nxt = RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_err      <= w_fgnt && !w_fetch_ok;
      r_load_err <= w_lgnt && !w_load_ok;
    end
  end

  // Outside a response cycle the last delivered word is replayed.
  always_comb begin
    w_rdata = r_rdata_hold;
    if (r_state == RESP) w_rdata = r_err ? NOP_INSN : bus.mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_rdata_hold <= 32'h0;
    else if (r_state == RESP) r_rdata_hold <= w_rdata;
  end

  assign bus.fetch_rvalid = (r_state == RESP);
  assign bus.fetch_err    = (r_state == RESP) && r_err;
  assign bus.fetch_rdata  = w_rdata;
  assign bus.load_err     = r_load_err;
  assign busy             = (r_state == RESP);

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
// Self-checking bench for imem_arbiter: directed sequences, a vector table
// and a randomized run against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef IMEM_ARB_LOAD_LOCK_EN
  logic load_lock;
`endif

  imem_arbiter_if #(.AW(AW)) bus();

  imem_arbiter #(.DEPTH_BYTES(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef IMEM_ARB_LOAD_LOCK_EN
    .load_lock (load_lock),
`endif
    .bus       (bus),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory with a backdoor write port for preloading.
  logic [31:0] mem_words [0:255];
  logic [31:0] rd_q;
  logic        bd_en;
  logic [7:0]  bd_idx;
  logic [31:0] bd_dat;

  always @(posedge clk) begin
    if (bd_en) begin
      mem_words[bd_idx] <= bd_dat;
    end else if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem_words[bus.mem_addr[AW-1:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
    if (bus.mem_en && !bus.mem_we) rd_q <= mem_words[bus.mem_addr[AW-1:2]];
  end
  assign bus.mem_rdata = rd_q;

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lr, input logic [31:0] la, input logic [31:0] lw,
                       input logic [3:0] lbe, input logic fr, input logic [31:0] fa);
    bus.load_req   = lr;
    bus.load_addr  = la;
    bus.load_wdata = lw;
    bus.load_be    = lbe;
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  // Every cycle starts 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Vector table: sequence starting from reset (loader has priority).
  typedef struct {
    logic        lr;
    logic [31:0] la;
    logic        fr;
    logic [31:0] fa;
    logic        elg, efg, een, ewe, erv, eerr, elerr;
  } vec_t;

  vec_t tbl[8];

  // Reference model state
  logic [7:0]  ref_mem [0:DEPTH-1];
  logic        m_last_load;
  logic        m_pend_f, m_pend_err, m_pend_lerr;
  logic [31:0] m_pend_data, m_hold;

  function automatic logic ref_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < DEPTH);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int i;
    i = int'(a);
    return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
  endfunction

  function automatic logic [31:0] pick_addr();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel == 0) return 32'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
    if (sel == 1) return 32'(DEPTH + 4 * $urandom_range(0, 4095));
    if (sel == 2) return 32'(4 * $urandom_range(0, 255));
    return 32'(4 * $urandom_range(0, 7));
  endfunction

  initial begin
    logic        lr, fr, elg, efg, fok, lok, een, ewe;
    logic [31:0] la, fa, lw, erd;
    logic [3:0]  lbe;

    reset  = 1'b1;
    bd_en  = 1'b0;
    bd_idx = 8'h0;
    bd_dat = 32'h0;
`ifdef IMEM_ARB_LOAD_LOCK_EN
    load_lock = 1'b0;
`endif
    idle();

    // Preload word0/word1 for the first fetch sequence
    bd_en = 1'b1; bd_idx = 8'd0; bd_dat = 32'h0010_2083; tick();
    bd_idx = 8'd1; bd_dat = 32'h0000_0113; tick();
    bd_en = 1'b0;

    // ---- reset state, with both sides requesting ----
    drive(1'b1, 32'h10, 32'h1, 4'hF, 1'b1, 32'h0);
    @(negedge clk);
    chk1("rst_fetch_gnt", bus.fetch_gnt, 1'b0);
    chk1("rst_load_gnt", bus.load_gnt, 1'b0);
    chk1("rst_rvalid", bus.fetch_rvalid, 1'b0);
    chk1("rst_ferr", bus.fetch_err, 1'b0);
    chk1("rst_lerr", bus.load_err, 1'b0);
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_rdata", bus.fetch_rdata, 32'h0);
    idle();
    tick();
    reset = 1'b0;

    // ---- two consecutive fetches ----
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    @(negedge clk);
    chk1("seq24_gnt0", bus.fetch_gnt, 1'b1);
    chk1("seq24_rv0", bus.fetch_rvalid, 1'b0);
    chk1("seq24_en0", bus.mem_en, 1'b1);
    chk32("seq24_be0", {28'h0, bus.mem_be}, 32'hF);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4);
    @(negedge clk);
    chk1("seq24_gnt1", bus.fetch_gnt, 1'b1);
    chk1("seq24_rv1", bus.fetch_rvalid, 1'b1);
    chk32("seq24_rdata1", bus.fetch_rdata, 32'h0010_2083);
    chk1("seq24_err1", bus.fetch_err, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk1("seq24_rv2", bus.fetch_rvalid, 1'b1);
    chk32("seq24_rdata2", bus.fetch_rdata, 32'h0000_0113);
    chk1("seq24_err2", bus.fetch_err, 1'b0);
    chk1("seq24_busy2", busy, 1'b1);
    tick();
    @(negedge clk);
    chk1("seq24_rv3", bus.fetch_rvalid, 1'b0);
    chk32("seq24_hold", bus.fetch_rdata, 32'h0000_0113);
    chk1("seq24_busy3", busy, 1'b0);
    tick();

    // ---- faulting fetches ----
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h2);
    @(negedge clk);
    chk1("flt_gnt0", bus.fetch_gnt, 1'b1);
    chk1("flt_en0", bus.mem_en, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h400);
    @(negedge clk);
    chk1("flt_gnt1", bus.fetch_gnt, 1'b1);
    chk1("flt_en1", bus.mem_en, 1'b0);
    chk1("flt_rv1", bus.fetch_rvalid, 1'b1);
    chk1("flt_err1", bus.fetch_err, 1'b1);
    chk32("flt_rdata1", bus.fetch_rdata, 32'h0000_0013);
    tick();
    idle();
    @(negedge clk);
    chk1("flt_rv2", bus.fetch_rvalid, 1'b1);
    chk1("flt_err2", bus.fetch_err, 1'b1);
    chk32("flt_rdata2", bus.fetch_rdata, 32'h0000_0013);
    tick();

    // ---- write then fetch same word next cycle ----
    drive(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    chk1("wr_gnt", bus.load_gnt, 1'b1);
    chk1("wr_en", bus.mem_en, 1'b1);
    chk1("wr_we", bus.mem_we, 1'b1);
    chk32("wr_addr", 32'(bus.mem_addr), 32'h8);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h8);
    @(negedge clk);
    chk1("raw_gnt", bus.fetch_gnt, 1'b1);
    chk1("raw_we", bus.mem_we, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk1("raw_rv", bus.fetch_rvalid, 1'b1);
    chk32("raw_rdata", bus.fetch_rdata, 32'hDEAD_BEEF);
    tick();

    // Partial byte-enable write merges into the old word
    drive(1'b1, 32'h8, 32'h1122_3344, 4'b0101, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h8);
    tick();
    idle();
    @(negedge clk);
    chk32("be_rdata", bus.fetch_rdata, 32'hDE22_BE44);
    tick();
    // Leave the pointer on "loader" so the next reset has something to clear
    drive(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0);
    tick();

    // ---- vector table ----
    tbl[0] = '{1'b1, 32'h10,  1'b1, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h10,  1'b1, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h14,  1'b1, 32'h4,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'h14,  1'b1, 32'h4,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h3,   1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 32'h800, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].lr, tbl[i].la, 32'h5A5A_0000 + 32'(i), 4'hF, tbl[i].fr, tbl[i].fa);
      @(negedge clk);
      chk1($sformatf("tbl%0d_lgnt", i), bus.load_gnt, tbl[i].elg);
      chk1($sformatf("tbl%0d_fgnt", i), bus.fetch_gnt, tbl[i].efg);
      chk1($sformatf("tbl%0d_en", i), bus.mem_en, tbl[i].een);
      chk1($sformatf("tbl%0d_we", i), bus.mem_we, tbl[i].ewe);
      chk1($sformatf("tbl%0d_rv", i), bus.fetch_rvalid, tbl[i].erv);
      chk1($sformatf("tbl%0d_ferr", i), bus.fetch_err, tbl[i].eerr);
      chk1($sformatf("tbl%0d_lerr", i), bus.load_err, tbl[i].elerr);
      tick();
    end

    // ---- reset while a read is in flight ----
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    @(negedge clk);
    chk1("rif_gnt", bus.fetch_gnt, 1'b1);
    tick();
    idle();
    reset = 1'b1;
    #1;
    chk1("rif_rv_async", bus.fetch_rvalid, 1'b0);
    chk1("rif_busy_async", busy, 1'b0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk1("rif_rv_after", bus.fetch_rvalid, 1'b0);
    chk1("rif_busy_after", busy, 1'b0);
    tick();
    drive(1'b1, 32'h30, 32'h0, 4'hF, 1'b1, 32'h0);
    @(negedge clk);
    chk1("rif_first_lgnt", bus.load_gnt, 1'b1);
    chk1("rif_first_fgnt", bus.fetch_gnt, 1'b0);
    tick();
    idle();
    tick();

`ifdef IMEM_ARB_LOAD_LOCK_EN
    // ---- loader lock: in-flight read completes, loader always wins ----
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    tick();
    load_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40, 32'h0, 4'hF, 1'b1, 32'h4);
      @(negedge clk);
      if (i == 0) chk1("lock_rv_inflight", bus.fetch_rvalid, 1'b1);
      chk1($sformatf("lock%0d_lgnt", i), bus.load_gnt, 1'b1);
      chk1($sformatf("lock%0d_fgnt", i), bus.fetch_gnt, 1'b0);
      tick();
    end
    load_lock = 1'b0;
    idle();
    tick();
`endif

    // ---- randomized run against the reference model ----
    for (int i = 0; i < 256; i++) begin
      bd_en  = 1'b1;
      bd_idx = 8'(i);
      bd_dat = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = bd_dat[b*8 +: 8];
      tick();
    end
    bd_en = 1'b0;
    do_reset();
    m_last_load = 1'b0;
    m_pend_f    = 1'b0;
    m_pend_err  = 1'b0;
    m_pend_lerr = 1'b0;
    m_pend_data = 32'h0;
    m_hold      = 32'h0;

    for (int c = 0; c < 600; c++) begin
      lr  = 1'($urandom_range(0, 1));
      fr  = 1'($urandom_range(0, 1));
      la  = pick_addr();
      fa  = pick_addr();
      lw  = $urandom;
      lbe = 4'($urandom_range(0, 15));
      drive(lr, la, lw, lbe, fr, fa);

      if (lr && fr) begin
        elg = !m_last_load;
        efg = m_last_load;
      end else begin
        elg = lr;
        efg = fr;
      end
      fok = ref_ok(fa);
      lok = ref_ok(la);
      een = (efg && fok) || (elg && lok);
      ewe = elg && lok;
      erd = m_pend_f ? m_pend_data : m_hold;

      @(negedge clk);
      chk1("rnd_lgnt", bus.load_gnt, elg);
      chk1("rnd_fgnt", bus.fetch_gnt, efg);
      chk1("rnd_en", bus.mem_en, een);
      chk1("rnd_we", bus.mem_we, ewe);
      chk1("rnd_rv", bus.fetch_rvalid, m_pend_f);
      chk1("rnd_ferr", bus.fetch_err, m_pend_err);
      chk1("rnd_lerr", bus.load_err, m_pend_lerr);
      chk1("rnd_busy", busy, m_pend_f);
      chk32("rnd_rdata", bus.fetch_rdata, erd);
      if (een) begin
        chk32("rnd_addr", 32'(bus.mem_addr), ewe ? (la % DEPTH) : (fa % DEPTH));
        if (ewe) chk32("rnd_be", {28'h0, bus.mem_be}, {28'h0, lbe});
      end

      if (m_pend_f) m_hold = m_pend_data;
      if (elg) m_last_load = 1'b1;
      else if (efg) m_last_load = 1'b0;
      if (elg && lok)
        for (int b = 0; b < 4; b++)
          if (lbe[b]) ref_mem[int'(la) + b] = lw[b*8 +: 8];
      m_pend_f    = efg;
      m_pend_err  = efg && !fok;
      m_pend_data = (efg && fok) ? ref_word(fa) : NOP_INSN;
      m_pend_lerr = elg && !lok;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
